// File: rtl/counter_pkg.sv
// Shared definitions for the 10..40 loadable up/down counter family:
// default bounds, data width, monitor FSM states and the next-count rule.
package counter_pkg;

  localparam int WIDTH = 8;
  localparam int LOW   = 10;
  localparam int HIGH  = 40;

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } mon_state_t;

  // Next legal counter value, in priority order: reset/out-of-range recovery,
  // load, count up with wrap HIGH->LOW, count down with wrap LOW->HIGH.
  // Operands are zero-extended to 32 bits; callers truncate to their width,
  // which gives the modulo 2^WIDTH behaviour of the +1/-1 steps.
  function automatic logic [31:0] next_count(
    input logic [31:0] cnt,
    input logic [31:0] d,
    input logic        rst_n,
    input logic        load,
    input logic        dir,
    input logic [31:0] low,
    input logic [31:0] high
  );
    logic [31:0] nxt;
    if (!rst_n || (cnt > high) || (cnt < low)) begin
      nxt = low;
    end else if (load) begin
      nxt = d;
    end else if (dir) begin
      nxt = (cnt >= high) ? low : cnt + 32'd1;
    end else begin
      nxt = (cnt <= low) ? high : cnt - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/counter_10_to_40_predictor.sv
// Combinational prediction of the counter's next output from the captured
// history, plus flags telling whether that prediction is a wrapping count step.
module counter_10_to_40_predictor
  import counter_pkg::*;
#(
  parameter int WIDTH = counter_pkg::WIDTH,
  parameter int LOW   = counter_pkg::LOW,
  parameter int HIGH  = counter_pkg::HIGH
) (
  input  logic [WIDTH-1:0] h_cnt,
  input  logic             h_rst_n,
  input  logic             h_load,
  input  logic [WIDTH-1:0] h_d,
  input  logic             h_dir,
  output logic [WIDTH-1:0] pred,
  output logic             step_wrap_up,
  output logic             step_wrap_dn
);

  localparam logic [WIDTH-1:0] LOW_W  = WIDTH'(LOW);
  localparam logic [WIDTH-1:0] HIGH_W = WIDTH'(HIGH);

  logic in_range;
  logic counting;

  assign in_range = (h_cnt >= LOW_W) && (h_cnt <= HIGH_W);
  assign counting = h_rst_n && in_range && !h_load;

  assign pred = WIDTH'(next_count(32'(h_cnt), 32'(h_d), h_rst_n, h_load, h_dir,
                                  32'(LOW), 32'(HIGH)));

  // Wraps only come from plain count steps, never from loads or recovery.
  assign step_wrap_up = counting &&  h_dir && (h_cnt == HIGH_W);
  assign step_wrap_dn = counting && !h_dir && (h_cnt == LOW_W);

endmodule

// File: rtl/counter_10_to_40_seq_monitor.sv
// Passive checker beside the 10..40 counter: captures what the counter saw,
// predicts its next output, and reports errors, wraps, range and lock.
module counter_10_to_40_seq_monitor
  import counter_pkg::*;
#(
  parameter int WIDTH    = counter_pkg::WIDTH,
  parameter int LOW      = counter_pkg::LOW,
  parameter int HIGH     = counter_pkg::HIGH,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic             mon_en_in,
  input  logic             cnt_rst_al_in,
  input  logic             load_en_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ahup_aldown,
  input  logic [WIDTH-1:0] count_in,
  output logic             err_out,
  output logic [ERR_W-1:0] err_cnt_out,
  output logic             wrap_up_out,
  output logic             wrap_dn_out,
  output logic             range_out,
  output logic             locked_out
);

  localparam int               LOCK_W   = $clog2(LOCK_CNT + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);
  localparam logic [WIDTH-1:0]  LOW_W    = WIDTH'(LOW);
  localparam logic [WIDTH-1:0]  HIGH_W   = WIDTH'(HIGH);

  mon_state_t        state_q, state_d;
  logic [WIDTH-1:0]  h_cnt;
  logic              h_rst_n;
  logic              h_load;
  logic [WIDTH-1:0]  h_d;
  logic              h_dir;
  logic [WIDTH-1:0]  pred;
  logic              step_wrap_up;
  logic              step_wrap_dn;
  logic [LOCK_W-1:0] lock_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_inc;
  logic              checking;
  logic              match;
  logic              out_of_range;

  counter_10_to_40_predictor #(
    .WIDTH (WIDTH),
    .LOW   (LOW),
    .HIGH  (HIGH)
  ) u_predictor (
    .h_cnt        (h_cnt),
    .h_rst_n      (h_rst_n),
    .h_load       (h_load),
    .h_d          (h_d),
    .h_dir        (h_dir),
    .pred         (pred),
    .step_wrap_up (step_wrap_up),
    .step_wrap_dn (step_wrap_dn)
  );

  assign checking     = (state_q == CHECK) && mon_en_in;
  assign match        = (count_in == pred);
  assign out_of_range = (count_in < LOW_W) || (count_in > HIGH_W);
  assign lock_cnt_inc = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 1'b1;

  // Capture the counter's output and controls on every enabled sample.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      h_cnt   <= '0;
      h_rst_n <= 1'b0;
      h_load  <= 1'b0;
      h_d     <= '0;
      h_dir   <= 1'b0;
    end else if (mon_en_in) begin
      h_cnt   <= count_in;
      h_rst_n <= cnt_rst_al_in;
      h_load  <= load_en_in;
      h_d     <= d_in;
      h_dir   <= ahup_aldown;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // A disabled cycle always falls back to HUNT; an enabled one leads to CHECK.
  always_comb begin
    state_d = state_q;
    if (mon_en_in) begin
      state_d = CHECK;
    end else begin
      state_d = HUNT;
    end
  end

  // Pulse outputs, saturating error count and lock tracking.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      err_out     <= 1'b0;
      err_cnt_out <= '0;
      wrap_up_out <= 1'b0;
      wrap_dn_out <= 1'b0;
      range_out   <= 1'b0;
      locked_out  <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      err_out     <= checking && !match;
      wrap_up_out <= checking && match && step_wrap_up;
      wrap_dn_out <= checking && match && step_wrap_dn;
      range_out   <= checking && out_of_range;
      if (checking) begin
        if (match) begin
          lock_cnt_q <= lock_cnt_inc;
          locked_out <= (lock_cnt_inc == LOCK_MAX);
        end else begin
          lock_cnt_q <= '0;
          locked_out <= 1'b0;
          if (err_cnt_out != '1) begin
            err_cnt_out <= err_cnt_out + 1'b1;
          end
        end
      end else if (mon_en_in) begin
        lock_cnt_q <= '0;
        locked_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_10_to_40_seq_monitor.sv
// Directed self-checking bench for the 10..40 counter sequence monitor.
module tb_counter_10_to_40_seq_monitor;

  logic       clk;
  logic       reset_al_in;
  logic       mon_en_in;
  logic       cnt_rst_al_in;
  logic       load_en_in;
  logic [7:0] d_in;
  logic       ahup_aldown;
  logic [7:0] count_in;
  logic       err_out;
  logic [7:0] err_cnt_out;
  logic       wrap_up_out;
  logic       wrap_dn_out;
  logic       range_out;
  logic       locked_out;

  int n_assert = 0;
  int n_fail   = 0;

  counter_10_to_40_seq_monitor dut (
    .clk           (clk),
    .reset_al_in   (reset_al_in),
    .mon_en_in     (mon_en_in),
    .cnt_rst_al_in (cnt_rst_al_in),
    .load_en_in    (load_en_in),
    .d_in          (d_in),
    .ahup_aldown   (ahup_aldown),
    .count_in      (count_in),
    .err_out       (err_out),
    .err_cnt_out   (err_cnt_out),
    .wrap_up_out   (wrap_up_out),
    .wrap_dn_out   (wrap_dn_out),
    .range_out     (range_out),
    .locked_out    (locked_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample to the monitor, then settle just after the edge.
  task automatic applyStimulus(input logic en, input logic crst, input logic ld,
                               input logic [7:0] d, input logic dir,
                               input logic [7:0] cnt);
    mon_en_in     = en;
    cnt_rst_al_in = crst;
    load_en_in    = ld;
    d_in          = d;
    ahup_aldown   = dir;
    count_in      = cnt;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the hand-computed expectation.
  task automatic checkOutput(input string tag, input logic e_err, input logic [7:0] e_cnt,
                             input logic e_wu, input logic e_wd, input logic e_rng,
                             input logic e_lock);
    n_assert++;
    assert (err_out === e_err) else begin
      n_fail++;
      $error("[TB] FAIL %s err_out got %0b exp %0b", tag, err_out, e_err);
    end
    n_assert++;
    assert (err_cnt_out === e_cnt) else begin
      n_fail++;
      $error("[TB] FAIL %s err_cnt_out got %0d exp %0d", tag, err_cnt_out, e_cnt);
    end
    n_assert++;
    assert (wrap_up_out === e_wu) else begin
      n_fail++;
      $error("[TB] FAIL %s wrap_up_out got %0b exp %0b", tag, wrap_up_out, e_wu);
    end
    n_assert++;
    assert (wrap_dn_out === e_wd) else begin
      n_fail++;
      $error("[TB] FAIL %s wrap_dn_out got %0b exp %0b", tag, wrap_dn_out, e_wd);
    end
    n_assert++;
    assert (range_out === e_rng) else begin
      n_fail++;
      $error("[TB] FAIL %s range_out got %0b exp %0b", tag, range_out, e_rng);
    end
    n_assert++;
    assert (locked_out === e_lock) else begin
      n_fail++;
      $error("[TB] FAIL %s locked_out got %0b exp %0b", tag, locked_out, e_lock);
    end
  endtask

  initial begin
    reset_al_in   = 1'b0;
    mon_en_in     = 1'b0;
    cnt_rst_al_in = 1'b1;
    load_en_in    = 1'b0;
    d_in          = 8'd0;
    ahup_aldown   = 1'b1;
    count_in      = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_al_in = 1'b1;

    // 1: up count 10..40 then wrap to 10
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd10);
    checkOutput("t1_hunt", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int v = 11; v <= 40; v++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'(v));
      checkOutput($sformatf("t1_up%0d", v), 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, (v >= 13));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd10);
    checkOutput("t1_wrap", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd11);
    checkOutput("t1_after_wrap", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 2: load 25 at count 17, then an injected error and relock
    for (int v = 12; v <= 16; v++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'(v));
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd25, 1'b1, 8'd17);
    checkOutput("t2_load17", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd25);
    checkOutput("t2_got25", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd26);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd25, 1'b1, 8'd27);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd26);
    checkOutput("t2_inject", 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd27);
    checkOutput("t2_relock1", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd28);
    checkOutput("t2_relock2", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd29);
    checkOutput("t2_relock3", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3: legal load of out-of-range data, then recovery to LOW without wrap
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd50, 1'b1, 8'd30);
    checkOutput("t3_load50", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd50);
    checkOutput("t3_got50", 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd10);
    checkOutput("t3_recover", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4: down count through LOW, then counter reset beating load
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd11);
    checkOutput("t4_dn11", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd10);
    checkOutput("t4_dn10", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd40);
    checkOutput("t4_wrapdn", 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd30, 1'b0, 8'd39);
    checkOutput("t4_dn39", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd10);
    checkOutput("t4_rst_beats_load", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 5: error counter saturation
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd20);
    end
    checkOutput("t5_err101", 1'b1, 8'd101, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd20);
    end
    checkOutput("t5_saturate", 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: monitor disabled with random counts, then re-enabled through HUNT
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)));
      checkOutput($sformatf("t5_frozen%0d", i), 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd200);
    checkOutput("t5_rehunt", 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd10);
    checkOutput("t5_recheck", 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset between edges, first sample afterwards unchecked
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd11);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd99);
    #2;
    reset_al_in = 1'b0;
    #1;
    checkOutput("t6_async_reset", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_al_in = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd35);
    checkOutput("t6_hunt", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd36);
    checkOutput("t6_check", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
